// File: rtl/uart_word_tx.sv
// UART word transmitter: sends a WORD_SIZE-bit word as consecutive 8N1 frames,
// most significant byte first, with a start/ready handshake and a done pulse.
module uart_word_tx #(
    parameter int WORD_SIZE    = 16,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WORD_SIZE-1:0] data,
    output logic                 tx,
    output logic                 ready,
    output logic                 done
);
    localparam int NUM_BYTES = WORD_SIZE / 8;
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NUM_BYTES - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state;
    logic [WORD_SIZE-1:0] shift;
    logic [IDX_W-1:0]     byte_idx;
    logic [2:0]           bit_idx;
    logic [CNT_W-1:0]     baud_cnt;
    logic [7:0]           cur_byte;
    logic                 bit_end;

    // Byte currently on the wire; byte_idx counts down so the high byte goes first.
    assign cur_byte = 8'(shift >> {byte_idx, 3'b000});
    assign bit_end  = (baud_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            shift    <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud_cnt <= '0;
            tx       <= 1'b1;
            ready    <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && ready) begin
                        shift    <= data;
                        byte_idx <= IDX_TOP;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        state    <= START;
                        tx       <= 1'b0;
                        ready    <= 1'b0;
                    end
                end
                START, DATA, STOP: begin
                    if (!bit_end) begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end else begin
                        baud_cnt <= '0;
                        case (state)
                            START: begin
                                state   <= DATA;
                                bit_idx <= '0;
                                tx      <= cur_byte[0];
                            end
                            DATA: begin
                                if (bit_idx == 3'd7) begin
                                    state <= STOP;
                                    tx    <= 1'b1;
                                end else begin
                                    bit_idx <= bit_idx + 3'd1;
                                    tx      <= cur_byte[bit_idx + 3'd1];
                                end
                            end
                            default: begin
                                // Next frame follows the stop bit directly, no idle gap.
                                if (byte_idx != '0) begin
                                    byte_idx <= byte_idx - 1'b1;
                                    state    <= START;
                                    tx       <= 1'b0;
                                end else begin
                                    state <= IDLE;
                                    ready <= 1'b1;
                                    done  <= 1'b1;
                                    tx    <= 1'b1;
                                end
                            end
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
